// File: rtl/threshold_table_loader_pkg.sv
// -----------------------------------------------------------------------------
// threshold_table_loader_pkg
// Shared definitions for the threshold table loader:
//   state_t       - FSM state encoding (IDLE=0, WRITE=1, DONE=2)
//   DEFAULT_*     - default parameter values for the loader and its interface
//   satMax()      - largest table entry representable in a CNT_WIDTH-bit word
// -----------------------------------------------------------------------------
package threshold_table_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_VECTOR_WIDTH = 920;
    localparam int DEFAULT_CNT_WIDTH    = $clog2(DEFAULT_VECTOR_WIDTH);
    localparam int DEFAULT_MUL_WIDTH    = 16;
    localparam int DEFAULT_FRAC_BITS    = 8;

    // Saturation ceiling of a table entry, derived from the entry width.
    function automatic int satMax(input int cntWidth);
        return (1 << cntWidth) - 1;
    endfunction

endpackage

// File: rtl/threshold_table_loader_if.sv
// -----------------------------------------------------------------------------
// threshold_table_loader_if
// Control and RAM-write bus of the threshold table loader.
//   i_Start      - single-cycle request to (re)build the table
//   i_Abort      - cancel an in-progress build
//   i_ThrMul     - unsigned fixed-point factor K
//   o_BRAM_Addr  - table write address
//   o_BRAM_Din   - table entry
//   o_BRAM_En    - RAM enable
//   o_BRAM_WrEn  - RAM write enable
//   o_Busy       - build in progress
//   o_Done       - one-cycle pulse when a build completes
// master: the controller side (drives i_*), slave: the loader (drives o_*).
// -----------------------------------------------------------------------------
interface threshold_table_loader_if
    import threshold_table_loader_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int MUL_WIDTH = DEFAULT_MUL_WIDTH
);

    logic                 i_Start;
    logic                 i_Abort;
    logic [MUL_WIDTH-1:0] i_ThrMul;
    logic [CNT_WIDTH-1:0] o_BRAM_Addr;
    logic [CNT_WIDTH-1:0] o_BRAM_Din;
    logic                 o_BRAM_En;
    logic                 o_BRAM_WrEn;
    logic                 o_Busy;
    logic                 o_Done;

    modport master (
        output i_Start, i_Abort, i_ThrMul,
        input  o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn, o_Busy, o_Done
    );

    modport slave (
        input  i_Start, i_Abort, i_ThrMul,
        output o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn, o_Busy, o_Done
    );

endinterface

// File: rtl/threshold_table_loader.sv
// -----------------------------------------------------------------------------
// threshold_table_loader
// Fills the comparator's threshold RAM with entry[c] = min(floor(c*K/2^FRAC_BITS),
// 2^CNT_WIDTH-1) for c = 0..VECTOR_WIDTH, one entry per cycle, using a running
// accumulator instead of a multiplier.
// Ports:
//   clk   - clock
//   rstn  - synchronous, active-low reset
//   bus   - threshold_table_loader_if.slave (start/abort/K in, RAM write out)
// All bus outputs are registered, so the RAM sees each write one cycle after
// the FSM computes it.
// -----------------------------------------------------------------------------
module threshold_table_loader
    import threshold_table_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int MUL_WIDTH    = DEFAULT_MUL_WIDTH,
    parameter int FRAC_BITS    = DEFAULT_FRAC_BITS
) (
    input  logic clk,
    input  logic rstn,
    threshold_table_loader_if.slave bus
);

    localparam int ACC_WIDTH     = CNT_WIDTH + MUL_WIDTH;
    localparam int ACC_INT_WIDTH = ACC_WIDTH - FRAC_BITS;
    localparam int SAT_MAX       = satMax(CNT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [MUL_WIDTH-1:0]   kMul_q, kMul_d;

    logic [CNT_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   din_q, din_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ACC_INT_WIDTH-1:0] accInt;
    logic [CNT_WIDTH-1:0]     satVal;
    logic                     writing;

    // Integer part of the accumulator, clamped to the entry width.
    always_comb begin
        accInt = acc_q[ACC_WIDTH-1:FRAC_BITS];
        satVal = (accInt > ACC_INT_WIDTH'(SAT_MAX)) ? CNT_WIDTH'(SAT_MAX)
                                                    : accInt[CNT_WIDTH-1:0];
    end

    // Next-state logic: start latches K and clears the counters, each WRITE
    // cycle advances c and adds K to the accumulator, abort drops to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        kMul_d  = kMul_q;
        case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    kMul_d  = bus.i_ThrMul;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.i_Abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    acc_d = acc_q + ACC_WIDTH'(kMul_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs. An abort suppresses the write the FSM would
    // otherwise issue this cycle, so the last visible write is the one already
    // on the bus when the abort arrives.
    always_comb begin
        writing = (state_q == WRITE) && !bus.i_Abort;
        en_d    = writing;
        addr_d  = writing ? cnt_q  : '0;
        din_d   = writing ? satVal : '0;
        busy_d  = writing || (state_q == DONE);
        done_d  = (state_q == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            kMul_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            kMul_q  <= kMul_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_BRAM_Addr = addr_q;
    assign bus.o_BRAM_Din  = din_q;
    assign bus.o_BRAM_En   = en_q;
    assign bus.o_BRAM_WrEn = en_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Done      = done_q;

endmodule

// File: doc/threshold_table_loader.md
THRESHOLD_TABLE_LOADER -- requirements
Module: threshold_table_loader

Interface
REQ-001 Parameters:
- VECTOR_WIDTH, 920, max popcount; the table holds VECTOR_WIDTH+1 entries.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), address and data width; matches the comparator's result RAM.
- MUL_WIDTH, 16, width of the fixed-point multiplier.
- FRAC_BITS, 8, fractional bits of the multiplier.

REQ-002 Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- i_Start  in  1  single-cycle request to (re)build the table.
- i_Abort  in  1  cancel an in-progress build.
- i_ThrMul  in  MUL_WIDTH  unsigned fixed-point factor K (threshold-derived), FRAC_BITS fraction.
- o_BRAM_Addr  out  CNT_WIDTH  table write address; drives the comparator's i_BRAM_Addr.
- o_BRAM_Din  out  CNT_WIDTH  table entry; drives the comparator's i_BRAM_Din.
- o_BRAM_En  out  1  RAM enable.
- o_BRAM_WrEn  out  1  RAM write enable.
- o_Busy  out  1  high while a build is in progress.
- o_Done  out  1  one-cycle pulse when a build completes.

Function
REQ-003 FSM states: IDLE, WRITE, DONE.
REQ-004 IDLE: when i_Start=1, latch i_ThrMul into K_r, clear counter c and accumulator acc, and enter WRITE on the next edge.
REQ-005 WRITE, per cycle:
- o_BRAM_En=1, o_BRAM_WrEn=1, o_BRAM_Addr=c, o_BRAM_Din=sat(acc>>FRAC_BITS).
- Next edge: c<=c+1, acc<=acc+K_r.
REQ-006 acc width is CNT_WIDTH+MUL_WIDTH bits, so no overflow occurs.
REQ-007 sat(x) = x if x <= 2^CNT_WIDTH-1, else 2^CNT_WIDTH-1.
REQ-008 Net entry written: entry[c] = min(floor(c*K_r/2^FRAC_BITS), 2^CNT_WIDTH-1).
REQ-009 The write with c=VECTOR_WIDTH is the last one; the FSM then enters DONE.
- A full build is exactly VECTOR_WIDTH+1 consecutive write cycles, with no gaps.
REQ-010 DONE lasts one cycle:
- o_Done=1, o_BRAM_En=0, o_BRAM_WrEn=0.
- Next state IDLE.
REQ-011 o_Busy=1 in WRITE and DONE; 0 in IDLE.
REQ-012 All outputs are registered. First write appears the second cycle after i_Start is sampled.
REQ-013 i_Start in WRITE or DONE is ignored. Changes to i_ThrMul after latching have no effect.
REQ-014 i_Abort in WRITE:
- The current cycle's write completes.
- Next state is IDLE, with o_BRAM_En and o_BRAM_WrEn low and no o_Done pulse.
- i_Abort in IDLE or DONE is ignored.
REQ-015 i_Abort and i_Start together in IDLE: i_Start wins (abort ignored).
REQ-016 K_r=0 yields all-zero entries; this is legal.
REQ-017 Outside WRITE, o_BRAM_Addr and o_BRAM_Din hold 0.

Reset
REQ-018 rstn=0 at a clock edge forces the following, overriding any in-progress build (no o_Done):
- state IDLE;
- c, acc, K_r = 0;
- all outputs 0.

Structure
REQ-019 The shared package holds the FSM state encoding (IDLE=0, WRITE=1, DONE=2) and the sat() width constants derived from CNT_WIDTH.
REQ-020 Single flat module with no sub-modules. A multiply-free accumulator replaces any multiplier.

Verification
REQ-021 Use VECTOR_WIDTH=9, CNT_WIDTH=4, FRAC_BITS=8, i_ThrMul=768 (3.0). Pulse i_Start.
- Required writes, addresses 0..9: 0,3,6,9,12,15,15,15,15,15.
- Then one o_Done pulse; o_Busy=1 for exactly 11 cycles.
REQ-022 i_ThrMul=384 (1.5) -> entries 0,1,3,4,6,7,9,10,12,13.
REQ-023 i_Abort asserted on the 4th write cycle:
- Writes to addresses 0..3 only.
- No o_Done; o_Busy falls the next cycle.
- A following i_Start produces a full 10-write build.
REQ-024 i_Start re-pulsed during WRITE, with i_ThrMul changed to 256 -> the table still matches the K=768 values; exactly one o_Done.
REQ-025 rstn=0 during WRITE at address 5 -> next cycle all outputs 0 and state IDLE; no o_Done.
REQ-026 i_Start and i_Abort asserted together in IDLE -> the build starts normally.
